// File: rtl/risc_v_32_i_pkg.sv
// rtl/risc_v_32_i_pkg.sv - shared ALU operation and ALU-share arbiter state types
//
// Purpose: types shared by the ALU and the blocks around it.
//   alu_select_e : ALU operation selector driven on alu_op_sel_i.
//   arb_state_e  : state encoding of the ALU share arbiter.
package risc_v_32_i_pkg;

  typedef enum logic [3:0] {
    OP_ADD     = 4'h0,
    OP_SUB     = 4'h1,
    OP_SLL     = 4'h2,
    OP_SLT     = 4'h3,
    OP_SLTU    = 4'h4,
    OP_XOR     = 4'h5,
    OP_SRL     = 4'h6,
    OP_SRA     = 4'h7,
    OP_OR      = 4'h8,
    OP_AND     = 4'h9,
    OP_UNKNOWN = 4'hF
  } alu_select_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// rtl/rr_priority_picker.sv - combinational round-robin first-set-bit picker
//
// Purpose: picks the first set bit of req searching upward from rr_ptr,
// wrapping from NUM_REQ-1 back to 0.
// Ports:
//   req       in   NUM_REQ  request vector
//   rr_ptr    in   IDX_W    index with highest priority this cycle
//   grant     out  NUM_REQ  one-hot grant (zero when no request)
//   grant_idx out  IDX_W    index of the granted bit (0 when no request)
//   any_req   out  1        at least one request present
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  logic [IDX_W:0]   sum;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // One extra bit of headroom so rr_ptr + k cannot overflow before the
      // modulo-NUM_REQ wrap, which also covers non-power-of-two counts.
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      idx = sum[IDX_W-1:0];
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin time-sharing of one ALU among NUM_REQ requesters
//
// Purpose: accepts one request at a time (round robin), registers its operands
// into the ALU, registers the ALU result and returns it to the owner.
// Ports:
//   clk_i, rst_ni              clock, async active-low reset
//   req_valid_i / req_ready_o  per-requester request handshake
//   req_a_i, req_b_i, req_op_i per-requester operands and operation
//   rsp_valid_o / rsp_ready_i  per-requester response handshake
//   rsp_data_o                 registered result shared by all requesters
//   alu_port_a_o/_b_o/op_sel_o to the ALU inputs (registered operands)
//   alu_result_i               from the ALU output
//   busy_o, grant_id_o         activity and current owner index
//   op_count_o                 saturating count of completed operations
module alu_share_arbiter
  import risc_v_32_i_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NUM_REQ = 4,
  parameter int CNT_W   = 16,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_REQ-1:0]  req_valid_i,
  output logic [NUM_REQ-1:0]  req_ready_o,
  input  logic [XLEN-1:0]     req_a_i [NUM_REQ],
  input  logic [XLEN-1:0]     req_b_i [NUM_REQ],
  input  alu_select_e         req_op_i [NUM_REQ],
  output logic [NUM_REQ-1:0]  rsp_valid_o,
  input  logic [NUM_REQ-1:0]  rsp_ready_i,
  output logic [XLEN-1:0]     rsp_data_o,
  output logic [XLEN-1:0]     alu_port_a_o,
  output logic [XLEN-1:0]     alu_port_b_o,
  output alu_select_e         alu_op_sel_o,
  input  logic [XLEN-1:0]     alu_result_i,
  output logic                busy_o,
  output logic [IDX_W-1:0]    grant_id_o,
  output logic [CNT_W-1:0]    op_count_o
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q;
  logic [IDX_W-1:0] grant_id_q;
  logic [XLEN-1:0]  a_q, b_q, result_q;
  alu_select_e      op_q;
  logic [CNT_W-1:0] cnt_q;

  logic [NUM_REQ-1:0] pick_grant;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic               accept;
  logic               rsp_done;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req       (req_valid_i),
    .rr_ptr    (rr_ptr_q),
    .grant     (pick_grant),
    .grant_idx (pick_idx),
    .any_req   (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_o = '0;
    rsp_valid_o = '0;
    accept      = 1'b0;
    rsp_done    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          req_ready_o = pick_grant;
          accept      = 1'b1;
          state_d     = ARB_EXEC;
        end
      end
      ARB_EXEC: begin
        state_d = ARB_RESP;
      end
      ARB_RESP: begin
        rsp_valid_o[grant_id_q] = 1'b1;
        // Only the owner's ready bit can complete the response.
        if (rsp_ready_i[grant_id_q]) begin
          rsp_done = 1'b1;
          state_d  = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= OP_UNKNOWN;
      result_q   <= '0;
      cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q        <= req_a_i[pick_idx];
        b_q        <= req_b_i[pick_idx];
        op_q       <= req_op_i[pick_idx];
        grant_id_q <= pick_idx;
      end
      if (state_q == ARB_EXEC) begin
        result_q <= alu_result_i;
      end
      if (rsp_done) begin
        // Priority moves to the requester after the one just served.
        rr_ptr_q <= (grant_id_q == IDX_W'(NUM_REQ-1)) ? '0 : grant_id_q + 1'b1;
        if (cnt_q != {CNT_W{1'b1}}) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign alu_port_a_o = a_q;
  assign alu_port_b_o = b_q;
  assign alu_op_sel_o = op_q;
  assign rsp_data_o   = result_q;
  assign busy_o       = (state_q != ARB_IDLE);
  assign grant_id_o   = grant_id_q;
  assign op_count_o   = cnt_q;

endmodule
